// File: rtl/addr_bus_xfer_ctrl.sv
// Round-robin sequencer for the shared 16-bit address bus: grants one requester at a time and
// times its source select and destination load strobes as select -> settle -> load -> hold.
module addr_bus_xfer_ctrl #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LOAD_CYC   = 1,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] req_src,
    input  logic [3*N_REQ-1:0] req_dst,
    output logic [N_REQ-1:0]   ack,
    output logic               err,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               sel_m,
    output logic               sel_xy,
    output logic               sel_j,
    output logic               sel_pc,
    output logic               sel_inc,
    output logic               ld_pc,
    output logic               ld_xy,
    output logic               ld_inc
);

    typedef enum logic [2:0] {StIdle, StSel, StLoad, StHold, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       src_q, src_d;
    logic [2:0]       dst_q, dst_d;
    logic [2:0]       gid_q, gid_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             err_q, err_d;

    logic             arb_found;
    logic [2:0]       arb_idx;
    logic [2:0]       arb_src;
    logic [2:0]       arb_dst;
    logic             sel_on;

    // First pass searches from the pointer upward; second pass wraps around to index 0.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_src   = '0;
        arb_dst   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!arb_found && req[k] && (k >= int'(ptr_q))) begin
                arb_found = 1'b1;
                arb_idx   = 3'(k);
                arb_src   = req_src[3*k +: 3];
                arb_dst   = req_dst[3*k +: 3];
            end
        end
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!arb_found && req[k]) begin
                arb_found = 1'b1;
                arb_idx   = 3'(k);
                arb_src   = req_src[3*k +: 3];
                arb_dst   = req_dst[3*k +: 3];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    gid_d = arb_idx;
                    src_d = arb_src;
                    dst_d = arb_dst;
                    if (arb_src < 3'd5) begin
                        state_d = StSel;
                        cnt_d   = CNT_W'(SETTLE_CYC - 1);
                        err_d   = 1'b0;
                    end else begin
                        // Invalid source never touches the bus; complete with an error.
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StSel: begin
                if (cnt_q == '0) begin
                    state_d = StLoad;
                    cnt_d   = CNT_W'(LOAD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StLoad: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                ptr_d   = (int'(gid_q) == int'(N_REQ) - 1) ? 3'd0 : gid_q + 3'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode the registered state only, so reset clears them immediately.
    always_comb begin
        sel_on   = (state_q == StSel) || (state_q == StLoad) || (state_q == StHold);
        sel_m    = sel_on && (src_q == 3'd0);
        sel_xy   = sel_on && (src_q == 3'd1);
        sel_j    = sel_on && (src_q == 3'd2);
        sel_pc   = sel_on && (src_q == 3'd3);
        sel_inc  = sel_on && (src_q == 3'd4);
        ld_pc    = (state_q == StLoad) && dst_q[0];
        ld_xy    = (state_q == StLoad) && dst_q[1];
        ld_inc   = (state_q == StLoad) && dst_q[2];
        busy     = (state_q != StIdle);
        err      = (state_q == StDone) && err_q;
        grant_id = gid_q;
        for (int k = 0; k < int'(N_REQ); k++) begin
            ack[k] = (state_q == StDone) && (int'(gid_q) == k);
        end
    end

endmodule
